// File: rtl/fifo_cell_array.sv
// Token-ring FIFO storage: N_CELLS data cells with per-cell full bits, one-hot
// put/get tokens, registered read port and per-cell empty flags for the detector.
module fifo_cell_array #(
   parameter int N_CELLS    = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_put,
   input  logic [DATA_WIDTH-1:0] data_put,
   output logic                  full,
   input  logic                  req_get,
   output logic [DATA_WIDTH-1:0] data_get,
   output logic                  valid_get,
   output logic [N_CELLS-1:0]    e_o
);

   logic [N_CELLS-1:0]    r_full_bit;
   logic [N_CELLS-1:0]    r_put_tok;
   logic [N_CELLS-1:0]    r_get_tok;
   logic [DATA_WIDTH-1:0] r_data [N_CELLS];
   logic [DATA_WIDTH-1:0] r_data_get;
   logic                  r_valid_get;

   logic                  w_put_acc;
   logic                  w_get_acc;
   logic [N_CELLS-1:0]    w_set;
   logic [N_CELLS-1:0]    w_clr;
   logic [DATA_WIDTH-1:0] w_rd_data;

   // When both tokens sit on one cell, exactly one of put/get can be accepted,
   // so the set and clear masks never overlap.
   assign full      = |(r_put_tok & r_full_bit);
   assign w_put_acc = req_put & ~full;
   assign w_get_acc = req_get & (|(r_get_tok & r_full_bit));
   assign w_set     = w_put_acc ? r_put_tok : '0;
   assign w_clr     = w_get_acc ? r_get_tok : '0;

   always_comb begin
      w_rd_data = '0;
      for (int i = 0; i < N_CELLS; i++) begin
         if (r_get_tok[i]) begin
            w_rd_data = w_rd_data | r_data[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_full_bit  <= '0;
         r_put_tok   <= N_CELLS'(1);
         r_get_tok   <= N_CELLS'(1);
         r_data_get  <= '0;
         r_valid_get <= 1'b0;
      end else begin
         r_full_bit  <= (r_full_bit | w_set) & ~w_clr;
         r_valid_get <= w_get_acc;
         if (w_put_acc) begin
            r_put_tok <= {r_put_tok[N_CELLS-2:0], r_put_tok[N_CELLS-1]};
         end
         if (w_get_acc) begin
            r_get_tok  <= {r_get_tok[N_CELLS-2:0], r_get_tok[N_CELLS-1]};
            r_data_get <= w_rd_data;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_CELLS; i++) begin
            r_data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CELLS; i++) begin
            if (w_set[i]) begin
               r_data[i] <= data_put;
            end
         end
      end
   end

   assign data_get  = r_data_get;
   assign valid_get = r_valid_get;
   assign e_o       = ~r_full_bit;

endmodule

// File: tb/tb_fifo_cell_array.sv
// Scoreboard bench for fifo_cell_array: fill, drain, wrap, concurrent traffic
// and asynchronous reset, with a small occupancy model for e_o/full.
module tb_fifo_cell_array;

   localparam int N  = 16;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_put;
   logic [DW-1:0] data_put;
   logic          full;
   logic          req_get;
   logic [DW-1:0] data_get;
   logic          valid_get;
   logic [N-1:0]  e_o;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] sb[$];
   logic [N-1:0]  m_full;
   int            m_p;
   int            m_g;

   fifo_cell_array #(.N_CELLS(N), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_put   (req_put),
      .data_put  (data_put),
      .full      (full),
      .req_get   (req_get),
      .data_get  (data_get),
      .valid_get (valid_get),
      .e_o       (e_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish within the time limit");
      $fatal(1);
   end

   task automatic model_reset();
      m_full = '0;
      m_p    = 0;
      m_g    = 0;
      sb.delete();
   endtask

   function automatic logic [DW-1:0] sb_pop();
      if (sb.size() == 0) return 'x;
      return sb.pop_front();
   endfunction

   // Drives one cycle of requests and advances the occupancy model.
   task automatic drive(input logic put, input logic [DW-1:0] d, input logic get,
                        output logic exp_v);
      logic pa;
      logic ga;
      req_put  = put;
      data_put = d;
      req_get  = get;
      pa = put && !m_full[m_p];
      ga = get && m_full[m_g];
      if (pa) sb.push_back(d);
      @(posedge clk);
      #1;
      if (pa) begin
         m_full[m_p] = 1'b1;
         m_p = (m_p + 1) % N;
      end
      if (ga) begin
         m_full[m_g] = 1'b0;
         m_g = (m_g + 1) % N;
      end
      exp_v   = ga;
      req_put = 1'b0;
      req_get = 1'b0;
      assert ($onehot(dut.r_put_tok) && $onehot(dut.r_get_tok))
      else begin
         errors++;
         $display("FAIL token_onehot put_tok=%b get_tok=%b required one-hot",
                  dut.r_put_tok, dut.r_get_tok);
      end
   endtask

   task automatic test_reset();
      logic ev;
      logic [DW-1:0] exp;
      drive(1'b1, 8'h5A, 1'b0, ev);
      drive(1'b1, 8'hC3, 1'b0, ev);
      drive(1'b0, 8'h00, 1'b1, ev);
      exp = sb_pop();
      checks++;
      if (valid_get !== 1'b1 || data_get !== exp) begin
         errors++;
         $display("FAIL reset_pre_get got v=%b d=%h required v=1 d=%h", valid_get, data_get, exp);
      end
      checks++;
      if (e_o !== 16'hFFFD) begin
         errors++;
         $display("FAIL reset_pre_eo got %h required FFFD", e_o);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (e_o !== 16'hFFFF || full !== 1'b0 || valid_get !== 1'b0 || data_get !== 8'h00) begin
         errors++;
         $display("FAIL reset_async got e_o=%h full=%b v=%b d=%h required FFFF 0 0 00",
                  e_o, full, valid_get, data_get);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      model_reset();
   endtask

   task automatic test_fill();
      logic ev;
      for (int i = 0; i < N; i++) begin
         drive(1'b1, DW'(i), 1'b0, ev);
         checks++;
         if (e_o !== (16'hFFFF << (i + 1))) begin
            errors++;
            $display("FAIL fill_eo[%0d] got %h required %h", i, e_o, 16'hFFFF << (i + 1));
         end
         checks++;
         if (full !== (i == N - 1)) begin
            errors++;
            $display("FAIL fill_full[%0d] got %b required %b", i, full, i == N - 1);
         end
      end
      drive(1'b1, 8'hAA, 1'b0, ev);
      checks++;
      if (e_o !== 16'h0000 || full !== 1'b1) begin
         errors++;
         $display("FAIL fill_refused got e_o=%h full=%b required 0000 1", e_o, full);
      end
   endtask

   task automatic test_drain();
      logic ev;
      logic [DW-1:0] exp;
      for (int i = 0; i < N; i++) begin
         drive(1'b0, 8'h00, 1'b1, ev);
         checks++;
         if (valid_get !== 1'b1) begin
            errors++;
            $display("FAIL drain_valid[%0d] got %b required 1", i, valid_get);
         end
         exp = sb_pop();
         checks++;
         if (data_get !== exp || data_get !== DW'(i)) begin
            errors++;
            $display("FAIL drain_data[%0d] got %h required %h", i, data_get, DW'(i));
         end
         checks++;
         if (e_o !== ~m_full) begin
            errors++;
            $display("FAIL drain_eo[%0d] got %h required %h", i, e_o, ~m_full);
         end
      end
      drive(1'b0, 8'h00, 1'b1, ev);
      checks++;
      if (valid_get !== 1'b0 || data_get !== 8'h0F || e_o !== 16'hFFFF) begin
         errors++;
         $display("FAIL drain_empty got v=%b d=%h e_o=%h required 0 0F FFFF",
                  valid_get, data_get, e_o);
      end
   endtask

   task automatic test_wrap();
      logic ev;
      logic [DW-1:0] exp;
      int rx = 0;
      for (int k = 0; k < 20; k++) begin
         drive(1'b1, DW'(k), 1'b0, ev);
         checks++;
         if (e_o !== ~m_full || full !== 1'b0) begin
            errors++;
            $display("FAIL wrap_put[%0d] got e_o=%h full=%b required %h 0", k, e_o, full, ~m_full);
         end
         if (k % 4 == 3) begin
            for (int j = 0; j < 4; j++) begin
               drive(1'b0, 8'h00, 1'b1, ev);
               checks++;
               if (valid_get !== ev) begin
                  errors++;
                  $display("FAIL wrap_valid got %b required %b", valid_get, ev);
               end
               if (valid_get === 1'b1) begin
                  exp = sb_pop();
                  checks++;
                  if (data_get !== exp || data_get !== DW'(rx)) begin
                     errors++;
                     $display("FAIL wrap_data got %h required %h", data_get, DW'(rx));
                  end
                  rx++;
               end
            end
         end
      end
      checks++;
      if (rx !== 20 || e_o !== 16'hFFFF) begin
         errors++;
         $display("FAIL wrap_total got rx=%0d e_o=%h required 20 FFFF", rx, e_o);
      end
   endtask

   task automatic test_concurrent();
      logic ev;
      logic [DW-1:0] exp;
      for (int i = 0; i < 3; i++) drive(1'b1, DW'(8'h30 + i), 1'b0, ev);
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, DW'(8'h40 + i), 1'b1, ev);
         checks++;
         if (valid_get !== 1'b1) begin
            errors++;
            $display("FAIL conc_valid[%0d] got %b required 1", i, valid_get);
         end
         exp = sb_pop();
         checks++;
         if (data_get !== exp) begin
            errors++;
            $display("FAIL conc_data[%0d] got %h required %h", i, data_get, exp);
         end
         checks++;
         if ($countones(e_o) !== 13 || e_o !== ~m_full || full !== 1'b0) begin
            errors++;
            $display("FAIL conc_occ[%0d] got e_o=%h full=%b required %h 0", i, e_o, full, ~m_full);
         end
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 8'h00, 1'b1, ev);
         exp = sb_pop();
         checks++;
         if (valid_get !== 1'b1 || data_get !== exp) begin
            errors++;
            $display("FAIL conc_tail[%0d] got v=%b d=%h required 1 %h", i, valid_get, data_get, exp);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic ev;
      logic [DW-1:0] exp;
      for (int i = 0; i < 5; i++) drive(1'b1, DW'(8'h50 + i), 1'b0, ev);
      checks++;
      if (e_o !== ~m_full) begin
         errors++;
         $display("FAIL rmid_pre got %h required %h", e_o, ~m_full);
      end
      req_put  = 1'b1;
      data_put = 8'hEE;
      req_get  = 1'b1;
      #2 reset = 1'b0;
      #1;
      checks++;
      if (e_o !== 16'hFFFF || full !== 1'b0 || valid_get !== 1'b0) begin
         errors++;
         $display("FAIL rmid_async got e_o=%h full=%b v=%b required FFFF 0 0", e_o, full, valid_get);
      end
      @(posedge clk);
      #1;
      checks++;
      if (e_o !== 16'hFFFF || valid_get !== 1'b0) begin
         errors++;
         $display("FAIL rmid_held got e_o=%h v=%b required FFFF 0", e_o, valid_get);
      end
      req_put = 1'b0;
      req_get = 1'b0;
      reset   = 1'b1;
      model_reset();
      drive(1'b1, 8'h77, 1'b0, ev);
      checks++;
      if (e_o !== 16'hFFFE) begin
         errors++;
         $display("FAIL rmid_first_put got %h required FFFE", e_o);
      end
      drive(1'b0, 8'h00, 1'b1, ev);
      exp = sb_pop();
      checks++;
      if (valid_get !== 1'b1 || data_get !== exp) begin
         errors++;
         $display("FAIL rmid_readback got v=%b d=%h required 1 %h", valid_get, data_get, exp);
      end
   endtask

   initial begin
      reset    = 1'b0;
      req_put  = 1'b0;
      req_get  = 1'b0;
      data_put = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_concurrent();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
